// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: control/status bundle between the alarm logic and the chime sequencer.
// Ports:
//   start, stop   - one-cycle play / abort requests from the controller
//   half_period   - current tone half-period in clk cycles (0 = silence)
//   note_on       - high while half_period is non-zero
//   busy          - high while the score is playing
//   step          - current score index 0..31
//   done          - one-cycle pulse on natural completion
interface melody_sequencer_if;
   logic        start;
   logic        stop;
   logic [17:0] half_period;
   logic        note_on;
   logic        busy;
   logic [4:0]  step;
   logic        done;
   modport master (output start, stop, input half_period, note_on, busy, step, done);
   modport slave  (input start, stop, output half_period, note_on, busy, step, done);
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a fixed 32-note score at a programmable beat rate and emits tone half-periods.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of melody_sequencer_if (start/stop in; half_period, note_on, busy, step, done out)
// Parameters:
//   BEAT_CYCLES - clk cycles per score step (>= 2)
//   GAP_CYCLES  - silent cycles closing each step (< BEAT_CYCLES, 0 = legato)
//   LOOPS       - passes per start, 0 = repeat until stop
module melody_sequencer #(
   parameter int BEAT_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 1_250_000,
   parameter int LOOPS       = 1
) (
   input logic clk,
   input logic rst_n,
   melody_sequencer_if.slave bus
);
   localparam int BW = $clog2(BEAT_CYCLES) + 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
   localparam logic [BW-1:0] SOUND_END = BW'(BEAT_CYCLES - GAP_CYCLES);
   // index of the final pass; meaningless (and never compared) when LOOPS = 0
   localparam logic [7:0] LAST_PASS = 8'(LOOPS - 1);
   localparam logic [3:0] SCORE [32] = '{
      4'd0, 4'd0, 4'd12, 4'd0, 4'd12, 4'd12, 4'd8, 4'd0,
      4'd8, 4'd8, 4'd8,  4'd8, 4'd9,  4'd9,  4'd10, 4'd10,
      4'd0, 4'd0, 4'd12, 4'd0, 4'd12, 4'd12, 4'd8, 4'd0,
      4'd8, 4'd8, 4'd9,  4'd10, 4'd9, 4'd8,  4'd12, 4'd12};
   localparam logic [17:0] TONE [16] = '{
      18'd0,
      18'd127552, 18'd113636, 18'd101236, 18'd95548, 18'd85136, 18'd75838, 18'd67567,
      18'd63776,  18'd56818,  18'd50607,  18'd47778, 18'd42553, 18'd37936, 18'd33783,
      18'd0};
   typedef enum logic {IDLE, PLAY} state_t;
   state_t state, state_nx;
   logic [BW-1:0] beat_cnt, beat_nx;
   logic [7:0]    loop_cnt, loop_nx;
   logic [4:0]    step_nx;
   logic [17:0]   hp_nx;
   logic          done_nx;
   logic          wrap;
   assign wrap = beat_cnt == BEAT_LAST;
   always_comb begin
      state_nx = state;
      beat_nx  = beat_cnt;
      loop_nx  = loop_cnt;
      step_nx  = bus.step;
      done_nx  = 1'b0;
      if (state == IDLE) begin
         if (bus.start && !bus.stop) begin
            state_nx = PLAY;
            beat_nx  = '0;
            loop_nx  = '0;
            step_nx  = '0;
         end
      end else if (bus.stop) begin
         state_nx = IDLE;
         beat_nx  = '0;
         loop_nx  = '0;
         step_nx  = '0;
      end else begin
         beat_nx = wrap ? '0 : beat_cnt + 1'b1;
         if (wrap) begin
            step_nx = bus.step + 5'd1;
            if (bus.step == 5'd31) begin
               loop_nx = loop_cnt + 8'd1;
               if (LOOPS != 0 && loop_cnt == LAST_PASS) begin
                  state_nx = IDLE;
                  loop_nx  = '0;
                  step_nx  = '0;
                  done_nx  = 1'b1;
               end
            end
         end
      end
      // outputs are registered, so the tone is looked up from the next-cycle position
      hp_nx = (state_nx == PLAY && beat_nx < SOUND_END) ? TONE[SCORE[step_nx]] : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         beat_cnt        <= '0;
         loop_cnt        <= '0;
         bus.step        <= '0;
         bus.half_period <= '0;
         bus.note_on     <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
      end else begin
         state           <= state_nx;
         beat_cnt        <= beat_nx;
         loop_cnt        <= loop_nx;
         bus.step        <= step_nx;
         bus.half_period <= hp_nx;
         bus.note_on     <= hp_nx != '0;
         bus.busy        <= state_nx == PLAY;
         bus.done        <= done_nx;
      end
   end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Score sequencer for the clock's chime path. Steps through a fixed 32-entry note score at a programmable beat rate and emits the current note's tone half-period on every cycle. A downstream square-wave tone generator toggles the buzzer each time its counter reaches `half_period`. Play is started and stopped by single-cycle pulses from the alarm/control logic, and the block reports busy status and completion.

## Interface
- `BEAT_CYCLES`, default 25_000_000: clk cycles per score step (500 ms at 50 MHz); must be ≥ 2.
- `GAP_CYCLES`, default 1_250_000: silent cycles at the end of each step, so repeated notes articulate; 0 = legato; must be < `BEAT_CYCLES`.
- `LOOPS`, default 1: passes through the score per start; 0 = loop forever until stop.
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: one-cycle play request.
- `stop`, input, 1: one-cycle abort request.
- `half_period`, output, 18: tone half-period in clk cycles; 0 = silence.
- `note_on`, output, 1: high when `half_period` ≠ 0.
- `busy`, output, 1: high while playing.
- `step`, output, 5: current score index, 0–31.
- `done`, output, 1: one-cycle pulse on natural completion.

## Operation
- FSM has two states: IDLE and PLAY. All outputs are registered.
- Reset, and IDLE, values: `half_period` = 0, `note_on` = 0, `busy` = 0, `step` = 0, `done` = 0. Beat and loop counters are 0.
- IDLE with `start` = 1 and `stop` = 0: go to PLAY. Set `step` = 0, `beat_cnt` = 0, `busy` = 1.
- PLAY: `beat_cnt` increments every cycle.
  - At `beat_cnt` = `BEAT_CYCLES`−1, wrap `beat_cnt` to 0 and advance `step`.
  - `step` 31→0 increments `loop_cnt`.
  - If `LOOPS` ≠ 0 and the pass just completed was pass `LOOPS`, go to IDLE instead. Pulse `done` = 1 for one cycle; `busy` = 0.
- `stop` in PLAY: go to IDLE next cycle with reset values. `done` stays 0.
  - `stop` has priority over the beat boundary and over `start`.
- `start` during PLAY is ignored; the block does not restart.
- `start` and `stop` high together in IDLE: remain in IDLE.
- Note code table (4-bit code to half-period):
  - Codes 0 and 15: rest, value 0.
  - Low 1–7 (codes 1–7): 127552, 113636, 101236, 95548, 85136, 75838, 67567.
  - Mid 1–7 (codes 8–14): 63776, 56818, 50607, 47778, 42553, 37936, 33783.
- Score ROM, indices 0–31:
  - 0–15: 0,0,12,0,12,12,8,0,8,8,8,8,9,9,10,10
  - 16–31: 0,0,12,0,12,12,8,0,8,8,9,10,9,8,12,12
- In PLAY, `half_period` = table(score[step]) while `beat_cnt` < `BEAT_CYCLES`−`GAP_CYCLES`, else 0.
- Counter widths:
  - `beat_cnt` is wide enough for `BEAT_CYCLES`−1 (26 bits at default).
  - `loop_cnt` is 8 bits; when `LOOPS` = 0 it is not compared.

## Timing
- `start` is sampled at edge N. From cycle N+1: `busy` = 1, `step` = 0, `beat_cnt` = 0, `half_period` = table(score[0]).
- Each step lasts exactly `BEAT_CYCLES` cycles. The first `BEAT_CYCLES`−`GAP_CYCLES` cycles sound the note; the rest are silent.
- Natural end with `LOOPS` = L: `done` = 1 and `busy` = 0 in cycle N+1+32·L·`BEAT_CYCLES`. `done` returns to 0 the following cycle.
- `stop` is sampled at edge M. Silent, idle outputs from cycle M+1.
- `rst_n` asserted mid-play clears all outputs immediately, asynchronously. After release the block waits in IDLE for `start`.
- `note_on` changes in the same cycle as `half_period`.

## Test plan
Bench parameters: `BEAT_CYCLES` = 8, `GAP_CYCLES` = 2, `LOOPS` = 1, unless a scenario states otherwise.
- **Reset:** assert `rst_n` = 0, then release, no start → all outputs 0 for 20 cycles.
- **Start and note shape:** `start` pulse at cycle 0 → cycles 1–16 `half_period` = 0 (steps 0 and 1). Cycles 17–22 `half_period` = 42553 with `note_on` = 1. Cycles 23–24 `half_period` = 0. Cycle 25 `step` = 3, `half_period` = 0.
- **Full pass:** `start` at cycle 0 → `busy` = 1 on cycles 1–256. `done` = 1 only at cycle 257, with `busy` = 0. `step` reads 31 on cycles 249–256.
- **Stop mid-note:** `stop` at cycle 20 → cycle 21 all outputs 0, `done` never pulses. A later `start` restarts at `step` 0.
- **Conflicting controls:** `start` + `stop` together in IDLE → stays IDLE. A `start` pulse at cycle 50 of play → `step` and `beat_cnt` are unaffected.
- **Infinite loop and reset mid-play:** `LOOPS` = 0 → `step` wraps 31→0 at cycle 257 and no `done` within 1000 cycles. `rst_n` low at cycle 600 → outputs 0 immediately, before the next clock edge.
